sensor_ctrl: RTL

Sensor acquisition controller: polls the external sensor port (`sensor_en` / `sensor_ready` / `sensor_out`) and captures a burst of 32-bit samples into a local buffer. When the buffer is full it raises an interrupt to the CPU. The CPU reads the buffer through a simple registered-read port and releases it with a clear strobe. It sits inside `top`, between the chip-level sensor pins and the CPU-side peripheral wrapper.

---
 rtl/sensor_ctrl_pkg.sv | 13 +
 rtl/sensor_ctrl_if.sv | 31 +++
 rtl/sensor_buf.sv | 38 +++
 rtl/sensor_ctrl.sv | 89 ++++++++
 4 files changed

// File: rtl/sensor_ctrl_pkg.sv
// Shared types and default sizing for the sensor acquisition controller.
package sensor_ctrl_pkg;

    localparam int unsigned SCTRL_DEPTH  = 64;
    localparam int unsigned SCTRL_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } sctrl_state_t;

endpackage

// File: rtl/sensor_ctrl_if.sv
// CPU-side and sensor-side signal bundle; slave is the controller, master the environment.
interface sensor_ctrl_if
    import sensor_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = SCTRL_DEPTH,
    parameter int unsigned DATA_W = SCTRL_DATA_W
) ();

    localparam int unsigned AW = $clog2(DEPTH);

    logic              sctrl_en;
    logic              sctrl_clear;
    logic [AW-1:0]     sctrl_addr;
    logic [DATA_W-1:0] sctrl_out;
    logic [AW:0]       sctrl_count;
    logic              sctrl_interrupt;
    logic              sensor_ready;
    logic [DATA_W-1:0] sensor_out;
    logic              sensor_en;

    modport slave (
        input  sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
        output sctrl_out, sctrl_count, sctrl_interrupt, sensor_en
    );

    modport master (
        output sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
        input  sctrl_out, sctrl_count, sctrl_interrupt, sensor_en
    );

endinterface

// File: rtl/sensor_buf.sv
// Sample buffer: one write port, one registered read port; array has no reset so it can map to SRAM.
module sensor_buf
    import sensor_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = SCTRL_DEPTH,
    parameter int unsigned DATA_W = SCTRL_DATA_W,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-address read during a write returns the pre-write word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sensor_ctrl.sv
// Sensor burst acquisition: FSM, sample counter and output decode around the sample buffer.
module sensor_ctrl
    import sensor_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = SCTRL_DEPTH,
    parameter int unsigned DATA_W = SCTRL_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    sensor_ctrl_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    sctrl_state_t  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          sensor_en_q;
    logic          irq_q;
    logic          wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            sensor_en_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sensor_en_q <= (state_d == FILL);
            irq_q       <= (state_d == FULL);
        end
    end

    // Clear overrides everything, including a coincident sample.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        if (bus.sctrl_clear) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.sctrl_en) begin
                        state_d = FILL;
                    end
                end
                FILL: begin
                    if (bus.sensor_ready) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                    if (bus.sensor_ready && (count_q == CW'(DEPTH - 1))) begin
                        state_d = FULL;
                    end else if (!bus.sctrl_en) begin
                        state_d = IDLE;
                    end
                end
                FULL: begin
                    state_d = FULL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    sensor_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (bus.sensor_out),
        .raddr_i (bus.sctrl_addr),
        .rdata_o (bus.sctrl_out)
    );

    assign bus.sctrl_count     = count_q;
    assign bus.sensor_en       = sensor_en_q;
    assign bus.sctrl_interrupt = irq_q;

endmodule
